// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, the instruction memory and the decode/execute controller.
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               imem_eof;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_target;
    logic               done;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, done,
        input  imem_data, imem_eof, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, done,
        output imem_data, imem_eof, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, reads the synchronous instruction memory, buffers results in a
// small prefetch FIFO for the controller, and handles branch redirects and end of program.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [PC_W-1:0]    fetch_pc;
    logic               inflight, inflight_epoch, epoch;
    logic [PC_W-1:0]    inflight_pc;
    logic [CNT_W-1:0]   count, count_next;
    logic [PTR_W-1:0]   head, tail;
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem   [DEPTH];

    logic valid, pop, push, req, redirect_take, resp_live, resp_eof;

    assign valid = (count != '0) && (state != HALT);
    assign pop   = valid && bus.instr_ready;

    // A response is live only if it belongs to the current epoch and is not overtaken by a
    // redirect; a live eof response blocks the request of that cycle so nothing past the end is read.
    always_comb begin
        redirect_take = bus.redirect && (state != HALT);
        resp_live     = inflight && (inflight_epoch == epoch) && !redirect_take && (state == RUN);
        resp_eof      = resp_live && bus.imem_eof;
        push          = resp_live && !bus.imem_eof;
        req           = !reset && (state == RUN) && !resp_eof &&
                        ((int'(count) + int'(inflight) - int'(pop)) < DEPTH);
        count_next    = redirect_take ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Halting looks at next-cycle occupancy so done rises right after the last handshake.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (resp_eof) state_next = (count_next == '0) ? HALT : DRAIN;
            end
            DRAIN: begin
                if (redirect_take)          state_next = RUN;
                else if (count_next == '0)  state_next = HALT;
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc       <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            epoch          <= 1'b0;
            count          <= '0;
            head           <= '0;
            tail           <= '0;
        end else begin
            inflight       <= req;
            inflight_epoch <= epoch;
            inflight_pc    <= fetch_pc;
            count          <= count_next;
            if (redirect_take) begin
                fetch_pc <= bus.redirect_target;
                epoch    <= ~epoch;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (req)  fetch_pc <= fetch_pc + PC_W'(1);
                if (push) tail     <= tail + PTR_W'(1);
                if (pop)  head     <= head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail] <= bus.imem_data;
            pc_mem[tail]   <= inflight_pc;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? data_mem[head] : '0;
    assign bus.instr_pc    = valid ? pc_mem[head] : '0;
    assign bus.done        = (state == HALT);
endmodule
